// File: rtl/fpu_sched.sv
// fpu_sched - issue scheduler and writeback sequencer for the multi-latency FPU.
//
// Accepts one FP op per cycle from decode over a valid/ready handshake.
// An op is held back on RAW/WAW register hazards and when its writeback
// would land on a cycle that already has a writeback booked. Each accepted
// op is presented to the datapath one cycle later (iss_*). The matching
// register-file write (wb_*) is presented exactly L cycles after acceptance,
// where L is the latency of the op's ctrl code.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush               synchronous kill of every in-flight op
//   in_valid/in_ready   decode handshake; the op is accepted when both are high
//   in_ctrl, in_dd      op code and destination register
//   in_ds, in_dt        source registers, qualified by in_ds_used/in_dt_used
//   iss_valid/ctrl/dd   registered issue of the accepted op to the datapath
//   wb_valid/addr/ctrl  registered register-file write that is due this cycle
//   idle                no booked writebacks and no pending registers
module fpu_sched #(
   parameter int LAT_ADD  = 2,
   parameter int LAT_MUL  = 2,
   parameter int LAT_INV  = 4,
   parameter int LAT_SQRT = 4,
   parameter int LAT_CVT  = 2,
   parameter int MAXLAT   = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_ctrl,
   input  logic [5:0] in_dd,
   input  logic [5:0] in_ds,
   input  logic [5:0] in_dt,
   input  logic       in_ds_used,
   input  logic       in_dt_used,
   output logic       iss_valid,
   output logic [3:0] iss_ctrl,
   output logic [5:0] iss_dd,
   output logic       wb_valid,
   output logic [5:0] wb_addr,
   output logic [3:0] wb_ctrl,
   output logic       idle
);

   // rsv_q[k]: a writeback is presented k cycles from now. Slot 0 is the
   // writeback of the current cycle, so it directly drives wb_*.
   logic [MAXLAT-1:0]      rsv_q, rsv_d;
   logic [MAXLAT-1:0][5:0] tag_addr_q, tag_addr_d;
   logic [MAXLAT-1:0][3:0] tag_ctrl_q, tag_ctrl_d;
   logic [63:0]            pend_q, pend_d;

   logic       iss_valid_q;
   logic [3:0] iss_ctrl_q;
   logic [5:0] iss_dd_q;

   int          lat_s;
   logic        writer_s;
   logic        coll_s;
   logic        src_hz_s;
   logic        ready_s;
   logic        fire_s;
   logic [63:0] pend_set_s;
   logic [63:0] pend_clr_s;

   // Result latency of each op code; ops without a pipelined unit take 1.
   function automatic int lat_of(input logic [3:0] c);
      case (c)
         4'd1, 4'd2:  lat_of = LAT_ADD;
         4'd3:        lat_of = LAT_MUL;
         4'd4:        lat_of = LAT_INV;
         4'd5:        lat_of = LAT_SQRT;
         4'd9, 4'd10: lat_of = LAT_CVT;
         default:     lat_of = 1;
      endcase
   endfunction

   // Hazard and writeback-collision checks that form the ready decision.
   always_comb begin
      lat_s    = lat_of(in_ctrl);
      writer_s = (in_ctrl != 4'd0) && (in_ctrl != 4'd15) && (in_dd != 6'd0);
      // Slot L right now becomes slot L-1 after the edge, which is where a new
      // reservation would be placed. L == MAXLAT matches no slot, so it never collides.
      coll_s   = 1'b0;
      for (int k = 0; k < MAXLAT; k++) begin
         coll_s = coll_s | (rsv_q[k] & (lat_s == k));
      end
      src_hz_s = (in_ds_used && pend_q[in_ds]) || (in_dt_used && pend_q[in_dt]);
      ready_s  = !rst && !flush && !src_hz_s && !(writer_s && (pend_q[in_dd] || coll_s));
      fire_s   = in_valid && ready_s;
   end

   // Next state of the reservation window, its tags and the scoreboard.
   always_comb begin
      for (int k = 0; k < MAXLAT - 1; k++) begin
         rsv_d[k]      = rsv_q[k+1];
         tag_addr_d[k] = tag_addr_q[k+1];
         tag_ctrl_d[k] = tag_ctrl_q[k+1];
      end
      rsv_d[MAXLAT-1]      = 1'b0;
      tag_addr_d[MAXLAT-1] = 6'd0;
      tag_ctrl_d[MAXLAT-1] = 4'd0;
      // Book the new writeback so that it reaches slot 0 exactly L cycles after the fire cycle.
      for (int k = 0; k < MAXLAT; k++) begin
         rsv_d[k]      = rsv_d[k] | (fire_s && writer_s && (lat_s == k + 1));
         tag_addr_d[k] = (fire_s && writer_s && (lat_s == k + 1)) ? in_dd   : tag_addr_d[k];
         tag_ctrl_d[k] = (fire_s && writer_s && (lat_s == k + 1)) ? in_ctrl : tag_ctrl_d[k];
      end
      // The register being written back this cycle frees up at this edge; the
      // set can never hit the same register because a WAW hazard stalls.
      pend_clr_s = rsv_q[0] ? (64'd1 << tag_addr_q[0]) : 64'd0;
      pend_set_s = (fire_s && writer_s) ? (64'd1 << in_dd) : 64'd0;
      pend_d     = (pend_q & ~pend_clr_s) | pend_set_s;
   end

   // State registers; reset and flush both discard every in-flight op.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rsv_q       <= '0;
         tag_addr_q  <= '0;
         tag_ctrl_q  <= '0;
         pend_q      <= 64'd0;
         iss_valid_q <= 1'b0;
         iss_ctrl_q  <= 4'd0;
         iss_dd_q    <= 6'd0;
      end else begin
         rsv_q       <= rsv_d;
         tag_addr_q  <= tag_addr_d;
         tag_ctrl_q  <= tag_ctrl_d;
         pend_q      <= pend_d;
         iss_valid_q <= fire_s;
         if (fire_s) begin
            iss_ctrl_q <= in_ctrl;
            iss_dd_q   <= in_dd;
         end
      end
   end

   assign in_ready  = ready_s;
   assign iss_valid = iss_valid_q;
   assign iss_ctrl  = iss_ctrl_q;
   assign iss_dd    = iss_dd_q;
   assign wb_valid  = rsv_q[0];
   assign wb_addr   = tag_addr_q[0];
   assign wb_ctrl   = tag_ctrl_q[0];
   assign idle      = (rsv_q == '0) && (pend_q == 64'd0);

endmodule
